// File: rtl/scoreboard_hazard_unit.sv
// Register scoreboard between decode and issue: RAW/WAW stall, cycles-to-clear, branch kill window.
// Hazard outputs are combinational on the decode inputs; stall holds decode, nothing is accepted while stall or kill.
module scoreboard_hazard_unit #(
    parameter int NREGS       = 32,
    parameter int AW          = 5,
    parameter int LAT_W       = 3,
    parameter int ALU_LAT     = 1,
    parameter int LOAD_LAT    = 3,
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 7,
    parameter int KILL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             issue_valid,
    input  logic [6:0]       op_code,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic             btaken,
    output logic             stall,
    output logic             kill,
    output logic [LAT_W-1:0] stall_cycles,
    output logic [NREGS-1:0] busy_vec
);

    localparam logic [LAT_W-1:0] ALU_M1  = LAT_W'(ALU_LAT - 1);
    localparam logic [LAT_W-1:0] LOAD_M1 = LAT_W'(LOAD_LAT - 1);
    localparam logic [LAT_W-1:0] MUL_M1  = LAT_W'(MUL_LAT - 1);
    localparam logic [LAT_W-1:0] DIV_M1  = LAT_W'(DIV_LAT - 1);
    localparam logic [1:0]       KILL_LD = 2'(KILL_CYCLES);

    logic [LAT_W-1:0] cnt_q [NREGS];
    logic [LAT_W-1:0] cnt_d [NREGS];
    logic [1:0]       kcnt_q, kcnt_d;

    logic             dec_rs1, dec_rs2, dec_rd;
    logic [LAT_W-1:0] lat_m1;
    logic             src1_used, src2_used, dst_used;
    logic             raw1, raw2, waw, alloc;
    logic [LAT_W-1:0] cyc1, cyc2, cycw, cyc12;

    always_comb begin
        dec_rs1 = 1'b0;
        dec_rs2 = 1'b0;
        dec_rd  = 1'b0;
        lat_m1  = ALU_M1;
        case (op_code)
            7'b0110111, 7'b0010111, 7'b1101111: dec_rd = 1'b1;
            7'b1100111, 7'b0010011: begin
                dec_rs1 = 1'b1;
                dec_rd  = 1'b1;
            end
            7'b1100011, 7'b0100011: begin
                dec_rs1 = 1'b1;
                dec_rs2 = 1'b1;
            end
            7'b0000011: begin
                dec_rs1 = 1'b1;
                dec_rd  = 1'b1;
                lat_m1  = LOAD_M1;
            end
            7'b0110011: begin
                dec_rs1 = 1'b1;
                dec_rs2 = 1'b1;
                dec_rd  = 1'b1;
                if (funct7 == 7'b0000001) begin
                    lat_m1 = (funct3 inside {[3'd4:3'd7]}) ? DIV_M1 : MUL_M1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            busy_vec[i] = (cnt_q[i] != '0);
        end
    end

    assign src1_used = dec_rs1 && (rs1 != '0);
    assign src2_used = dec_rs2 && (rs2 != '0);
    assign dst_used  = dec_rd  && (rd  != '0);

    assign kill = (kcnt_q != 2'd0);
    assign raw1 = src1_used && busy_vec[rs1];
    assign raw2 = src2_used && busy_vec[rs2];
    // The new write must land strictly after the pending one.
    assign waw  = dst_used && busy_vec[rd] && (cnt_q[rd] >= lat_m1);

    assign stall = issue_valid && !kill && (raw1 || raw2 || waw);

    // Single-cycle classes wait for the old entry to drain completely.
    assign cyc1  = raw1 ? cnt_q[rs1] : '0;
    assign cyc2  = raw2 ? cnt_q[rs2] : '0;
    assign cycw  = !waw ? '0 :
                   (lat_m1 == '0) ? cnt_q[rd] : (cnt_q[rd] - lat_m1 + LAT_W'(1));
    assign cyc12 = (cyc1 > cyc2) ? cyc1 : cyc2;
    assign stall_cycles = !stall ? '0 : ((cyc12 > cycw) ? cyc12 : cycw);

    assign alloc = issue_valid && !stall && !kill && !btaken && dst_used && (lat_m1 != '0);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (alloc && (rd == AW'(i))) begin
                cnt_d[i] = lat_m1;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - LAT_W'(1);
            end
        end
        kcnt_d = kcnt_q;
        if (btaken) begin
            kcnt_d = KILL_LD;
        end else if (kcnt_q != 2'd0) begin
            kcnt_d = kcnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
            kcnt_q <= 2'd0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            kcnt_q <= kcnt_d;
        end
    end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed per-cycle vector table for scoreboard_hazard_unit plus a hand-written async reset sequence.
module tb_scoreboard_hazard_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] MULDIV   = 7'b0000001;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       issue_valid = 1'b0;
    logic [6:0] op_code = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       btaken = 1'b0;
    logic       stall, kill;
    logic [2:0] stall_cycles;
    logic [31:0] busy_vec;

    int tests = 0;
    int fails = 0;

    scoreboard_hazard_unit dut (
        .clk(clk), .nrst(nrst), .issue_valid(issue_valid), .op_code(op_code),
        .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .btaken(btaken), .stall(stall), .kill(kill), .stall_cycles(stall_cycles),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  s1, s2, d;
        logic        bt;
        logic        e_stall;
        logic        e_kill;
        logic [2:0]  e_sc;
        logic        chk_sc;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vt[64];
    int   nv = 0;

    function automatic logic [31:0] b(input int r);
        return 32'd1 << r;
    endfunction

    // sc < 0 leaves stall_cycles unchecked for that row
    task automatic push(input logic iv, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input int s1, input int s2, input int d,
                        input logic bt, input logic es, input logic ek, input int sc,
                        input logic [31:0] busy);
        vt[nv].iv = iv;  vt[nv].op = op;  vt[nv].f3 = f3;  vt[nv].f7 = f7;
        vt[nv].s1 = 5'(s1); vt[nv].s2 = 5'(s2); vt[nv].d = 5'(d);
        vt[nv].bt = bt;  vt[nv].e_stall = es; vt[nv].e_kill = ek;
        vt[nv].e_sc = (sc < 0) ? 3'd0 : 3'(sc);
        vt[nv].chk_sc = (sc >= 0);
        vt[nv].e_busy = busy;
        nv++;
    endtask

    task automatic idle(input logic bt, input logic ek, input logic [31:0] busy);
        push(1'b0, 7'd0, 3'd0, 7'd0, 0, 0, 0, bt, 1'b0, ek, 0, busy);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; op_code = v.op; funct3 = v.f3; funct7 = v.f7;
        rs1 = v.s1; rs2 = v.s2; rd = v.d; btaken = v.bt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // load-use: load x5, then add x6,x5,x7 stalls 2 cycles
        push(1, OP_LOAD, 3'd2, 7'd0, 1, 0, 5, 0, 0, 0, 0, 32'd0);
        push(1, OP_REG, 3'd0, 7'd0, 5, 7, 6, 0, 1, 0, 2, b(5));
        push(1, OP_REG, 3'd0, 7'd0, 5, 7, 6, 0, 1, 0, 1, b(5));
        push(1, OP_REG, 3'd0, 7'd0, 5, 7, 6, 0, 0, 0, 0, 32'd0);
        idle(0, 0, 32'd0);
        // ALU back-to-back: full forwarding
        push(1, OP_IMM, 3'd0, 7'd0, 0, 0, 5, 0, 0, 0, 0, 32'd0);
        push(1, OP_REG, 3'd0, 7'd0, 5, 5, 6, 0, 0, 0, 0, 32'd0);
        idle(0, 0, 32'd0);
        // mul x5, load x6, sw x5,0(x6)
        push(1, OP_REG, 3'd0, MULDIV, 1, 2, 5, 0, 0, 0, 0, 32'd0);
        push(1, OP_LOAD, 3'd2, 7'd0, 1, 0, 6, 0, 0, 0, 0, b(5));
        push(1, OP_STORE, 3'd2, 7'd0, 6, 5, 0, 0, 1, 0, 2, b(5) | b(6));
        push(1, OP_STORE, 3'd2, 7'd0, 6, 5, 0, 0, 1, 0, 1, b(5) | b(6));
        push(1, OP_STORE, 3'd2, 7'd0, 6, 5, 0, 0, 0, 0, 0, 32'd0);
        idle(0, 0, 32'd0);
        // WAW: div x8 then addi x8,x0,3 waits for the divide to drain
        push(1, OP_REG, 3'd4, MULDIV, 1, 2, 8, 0, 0, 0, 0, 32'd0);
        for (int k = 0; k < 6; k++) push(1, OP_IMM, 3'd0, 7'd0, 0, 0, 8, 0, 1, 0, -1, b(8));
        push(1, OP_IMM, 3'd0, 7'd0, 0, 0, 8, 0, 0, 0, 0, 32'd0);
        // WAW: div x8 then mul x8 issues once cnt8 < 3; then reallocation to 3
        push(1, OP_REG, 3'd5, MULDIV, 1, 2, 8, 0, 0, 0, 0, 32'd0);
        push(1, OP_REG, 3'd0, MULDIV, 1, 2, 8, 0, 1, 0, 4, b(8));
        push(1, OP_REG, 3'd0, MULDIV, 1, 2, 8, 0, 1, 0, 3, b(8));
        push(1, OP_REG, 3'd0, MULDIV, 1, 2, 8, 0, 1, 0, 2, b(8));
        push(1, OP_REG, 3'd0, MULDIV, 1, 2, 8, 0, 1, 0, 1, b(8));
        push(1, OP_REG, 3'd0, MULDIV, 1, 2, 8, 0, 0, 0, 0, b(8));
        idle(0, 0, b(8));
        idle(0, 0, b(8));
        idle(0, 0, b(8));
        idle(0, 0, 32'd0);
        // x0 destination never allocates; kill window with restart
        push(1, OP_LOAD, 3'd2, 7'd0, 1, 0, 0, 0, 0, 0, 0, 32'd0);
        push(1, OP_LOAD, 3'd2, 7'd0, 1, 0, 12, 0, 0, 0, 0, 32'd0);
        push(1, OP_LOAD, 3'd2, 7'd0, 1, 0, 9, 1, 0, 0, 0, b(12));
        push(1, OP_REG, 3'd0, 7'd0, 12, 0, 13, 1, 0, 1, 0, b(12));
        push(1, OP_REG, 3'd0, 7'd0, 9, 0, 13, 0, 0, 1, 0, 32'd0);
        push(1, OP_LOAD, 3'd2, 7'd0, 1, 0, 14, 0, 0, 1, 0, 32'd0);
        push(1, OP_REG, 3'd0, 7'd0, 9, 14, 13, 0, 0, 0, 0, 32'd0);
        // build up three pending entries ahead of the reset sequence
        push(1, OP_REG, 3'd6, MULDIV, 1, 2, 5, 0, 0, 0, 0, 32'd0);
        push(1, OP_REG, 3'd1, MULDIV, 1, 2, 4, 0, 0, 0, 0, b(5));
        push(1, OP_LOAD, 3'd2, 7'd0, 1, 0, 3, 0, 0, 0, 0, b(4) | b(5));
        idle(1, 0, b(3) | b(4) | b(5));

        #2;
        check("rst.busy_vec", busy_vec, 32'd0);
        check("rst.kill", {31'd0, kill}, 32'd0);
        check("rst.stall", {31'd0, stall}, 32'd0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < nv; i++) begin
            drive(vt[i]);
            #3;
            check($sformatf("v%0d.stall", i), {31'd0, stall}, {31'd0, vt[i].e_stall});
            check($sformatf("v%0d.kill", i), {31'd0, kill}, {31'd0, vt[i].e_kill});
            check($sformatf("v%0d.busy_vec", i), busy_vec, vt[i].e_busy);
            if (vt[i].chk_sc)
                check($sformatf("v%0d.stall_cycles", i), {29'd0, stall_cycles}, {29'd0, vt[i].e_sc});
            @(posedge clk);
            #1;
        end

        // async reset mid-cycle with three pending entries and kill active
        issue_valid = 1'b1; op_code = OP_REG; funct3 = 3'd0; funct7 = 7'd0;
        rs1 = 5'd5; rs2 = 5'd4; rd = 5'd6; btaken = 1'b0;
        #1;
        check("pre.busy_vec", busy_vec, b(3) | b(4) | b(5));
        check("pre.kill", {31'd0, kill}, 32'd1);
        nrst = 1'b0;
        #1;
        check("arst.busy_vec", busy_vec, 32'd0);
        check("arst.kill", {31'd0, kill}, 32'd0);
        check("arst.stall", {31'd0, stall}, 32'd0);
        check("arst.stall_cycles", {29'd0, stall_cycles}, 32'd0);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #3;
        check("post.stall", {31'd0, stall}, 32'd0);
        check("post.busy_vec", busy_vec, 32'd0);
        check("post.kill", {31'd0, kill}, 32'd0);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
